// File: rtl/uart_load_ctrl.sv
// Assembles UART byte pairs into 16-bit words and writes them to IMEM or DMEM,
// stalling the CPU while loading and returning one checksum byte per word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a hi byte with a valid target
// S_WAIT  | hi byte held, waiting for the lo byte (timeout running)
// S_WRITE | one-cycle memory write (or overflow drop) of {hi,lo}
module uart_load_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int IMEM_DEPTH  = 256,
  parameter int DMEM_DEPTH  = 256,
  parameter int TIMEOUT_CYC = 312480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [1:0]        uart_sel,
  input  logic              err_clr,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              err_ovf,
  output logic              err_tmo
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] IMEM_LIM = CNT_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0] DMEM_LIM = CNT_W'(DMEM_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t           state, state_nxt;
  logic             tgt_dmem;
  logic [7:0]       hi_q, lo_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] imem_cnt, dmem_cnt;
  logic             last_valid, last_dmem;
  logic             tx_pend;

  logic             hi_take, lo_take, tmo_hit, new_dmem, clr_new;
  logic             eff_last_valid, eff_last_dmem;
  logic [CNT_W-1:0] cur_cnt, cur_lim;
  logic             cur_full, in_write;

  assign in_write = (state == S_WRITE);
  assign new_dmem = (uart_sel == 2'd2);
  // A hi byte is only recognised outside S_WAIT; in S_WAIT any byte is the lo byte.
  assign hi_take  = rx_valid && (state != S_WAIT) &&
                    ((uart_sel == 2'd1) || (uart_sel == 2'd2));
  assign lo_take  = rx_valid && (state == S_WAIT);
  assign tmo_hit  = (state == S_WAIT) && !rx_valid && (tmo_cnt == TMO_LAST);

  assign cur_cnt  = tgt_dmem ? dmem_cnt : imem_cnt;
  assign cur_lim  = tgt_dmem ? DMEM_LIM : IMEM_LIM;
  assign cur_full = (cur_cnt == cur_lim);

  // A hi byte landing in S_WRITE must see the target being written as last_tgt.
  assign eff_last_valid = in_write ? 1'b1     : last_valid;
  assign eff_last_dmem  = in_write ? tgt_dmem : last_dmem;
  assign clr_new = hi_take && !(eff_last_valid && (eff_last_dmem == new_dmem));

  assign mem_addr  = cur_cnt[ADDR_W-1:0];
  assign mem_wdata = {hi_q, lo_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_we   = 1'b0;
    dmem_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (hi_take) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rx_valid)     state_nxt = S_WRITE;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_WRITE: begin
        imem_we   = !cur_full && !tgt_dmem;
        dmem_we   = !cur_full &&  tgt_dmem;
        state_nxt = hi_take ? S_WAIT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_dmem <= 1'b0;
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
      tmo_cnt  <= '0;
    end else begin
      if (hi_take) begin
        tgt_dmem <= new_dmem;
        hi_q     <= rx_data;
        tmo_cnt  <= '0;
      end else if (state == S_WAIT) begin
        tmo_cnt  <= tmo_cnt + TMO_W'(1);
      end
      if (lo_take) lo_q <= rx_data;
    end
  end

  // Clear and increment never hit the same counter in one cycle: an increment
  // implies that target is the effective last_tgt, which suppresses the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_cnt   <= '0;
      dmem_cnt   <= '0;
      last_valid <= 1'b0;
      last_dmem  <= 1'b0;
    end else begin
      if (clr_new && !new_dmem)
        imem_cnt <= '0;
      else if (in_write && !tgt_dmem && (imem_cnt != IMEM_LIM))
        imem_cnt <= imem_cnt + CNT_W'(1);

      if (clr_new && new_dmem)
        dmem_cnt <= '0;
      else if (in_write && tgt_dmem && (dmem_cnt != DMEM_LIM))
        dmem_cnt <= dmem_cnt + CNT_W'(1);

      if (in_write) begin
        last_valid <= 1'b1;
        last_dmem  <= tgt_dmem;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_pend  <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      if (in_write) begin
        tx_pend <= 1'b1;
        tx_data <= hi_q ^ lo_q;
      end else if (tx_pend && !tx_busy) begin
        tx_start <= 1'b1;
        tx_pend  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf   <= 1'b0;
      err_tmo   <= 1'b0;
      cpu_stall <= 1'b0;
    end else begin
      if (in_write && cur_full) err_ovf <= 1'b1;
      else if (err_clr)         err_ovf <= 1'b0;

      if (tmo_hit)      err_tmo <= 1'b1;
      else if (err_clr) err_tmo <= 1'b0;

      cpu_stall <= (uart_sel != 2'd0) || (state != S_IDLE) || tx_pend;
    end
  end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Bench for uart_load_ctrl: vector table, directed corner sequences and
// randomized words checked against a word-level memory/checksum model.
module tb_uart_load_ctrl;

  localparam int TMO  = 50;
  localparam int IDEP = 256;
  localparam int DDEP = 4;

  logic        clk, reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  uart_sel;
  logic        err_clr, tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        imem_we, dmem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_stall, err_ovf, err_tmo;

  uart_load_ctrl #(
    .ADDR_W(8), .IMEM_DEPTH(IDEP), .DMEM_DEPTH(DDEP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .uart_sel(uart_sel), .err_clr(err_clr), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .imem_we(imem_we),
    .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall), .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dmem;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] word;
    logic        exp_dmem;
    logic [7:0]  exp_addr;
  } vec_t;

  wr_t        got_wr[$], exp_wr[$];
  logic [7:0] got_tx[$], exp_tx[$];

  int checks = 0;
  int errors = 0;

  // word-level reference state
  int m_ptr[2];
  int m_last;
  bit m_ovf, m_tmo;

  always @(negedge clk) begin
    if (imem_we || dmem_we) got_wr.push_back(wr_t'({dmem_we, mem_addr, mem_wdata}));
    if (tx_start) got_tx.push_back(tx_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] s);
    rx_data  = b;
    uart_sel = s;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int g);
    repeat (g) @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic run_word(input logic [1:0] s_hi, input logic [1:0] s_lo,
                          input logic [15:0] w, input int gap);
    send_byte(w[15:8], s_hi);
    idle(gap);
    send_byte(w[7:0], s_lo);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    m_ovf = 1'b0;
    m_tmo = 1'b0;
  endtask

  // t: 0 = IMEM, 1 = DMEM
  task automatic model_word(input int t, input logic [15:0] w);
    int depth;
    depth = (t == 1) ? DDEP : IDEP;
    if (m_last != t) m_ptr[t] = 0;
    if (m_ptr[t] < depth) begin
      exp_wr.push_back(wr_t'({(t == 1), 8'(m_ptr[t]), w}));
      m_ptr[t]++;
    end else begin
      m_ovf = 1'b1;
    end
    m_last = t;
    exp_tx.push_back(w[15:8] ^ w[7:0]);
  endtask

  task automatic model_reset();
    m_ptr[0] = 0;
    m_ptr[1] = 0;
    m_last   = -1;
    m_ovf    = 1'b0;
    m_tmo    = 1'b0;
    exp_wr.delete();
    exp_tx.delete();
  endtask

  task automatic cmp_wr();
    wr_t g, e;
    chk("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
    while (got_wr.size() > 0 && exp_wr.size() > 0) begin
      g = got_wr.pop_front();
      e = exp_wr.pop_front();
      chk("wr_rec", 32'(g), 32'(e));
    end
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic cmp_tx();
    chk("tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
    while (got_tx.size() > 0 && exp_tx.size() > 0)
      chk("tx_byte", 32'(got_tx.pop_front()), 32'(exp_tx.pop_front()));
    got_tx.delete();
    exp_tx.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  vec_t vt[9];
  wr_t  r;
  int   s, g;
  logic [15:0] w;

  initial begin
    vt[0] = '{2'd1, 16'h20F2, 1'b0, 8'd0};
    vt[1] = '{2'd1, 16'h1104, 1'b0, 8'd1};
    vt[2] = '{2'd1, 16'h0113, 1'b0, 8'd2};
    vt[3] = '{2'd1, 16'h0024, 1'b0, 8'd3};
    vt[4] = '{2'd2, 16'h0064, 1'b1, 8'd0};
    vt[5] = '{2'd2, 16'h00C8, 1'b1, 8'd1};
    vt[6] = '{2'd2, 16'h012C, 1'b1, 8'd2};
    vt[7] = '{2'd2, 16'h0190, 1'b1, 8'd3};
    vt[8] = '{2'd1, 16'h0AAA, 1'b0, 8'd0};

    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; uart_sel = 2'd0;
    err_clr = 1'b0; tx_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({tx_start, tx_data, imem_we, dmem_we, mem_addr, mem_wdata,
                              cpu_stall, err_ovf, err_tmo}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    got_wr.delete(); got_tx.delete();

    // vector table: IMEM block, DMEM block, then back to IMEM from address 0
    for (int i = 0; i < 9; i++) begin
      run_word(vt[i].sel, vt[i].sel, vt[i].word, 2);
      model_word(int'(vt[i].sel) - 1, vt[i].word);
      settle();
      chk("tbl_we_count", 32'(got_wr.size()), 32'd1);
      if (got_wr.size() > 0) begin
        r = got_wr.pop_front();
        chk("tbl_target", 32'(r.dmem), 32'(vt[i].exp_dmem));
        chk("tbl_addr", 32'(r.addr), 32'(vt[i].exp_addr));
        chk("tbl_data", 32'(r.data), 32'(vt[i].word));
      end
      chk("tbl_next_addr", 32'(mem_addr), 32'(vt[i].exp_addr + 8'd1));
      chk("tbl_tx_count", 32'(got_tx.size()), 32'd1);
      if (got_tx.size() > 0)
        chk("tbl_tx_data", 32'(got_tx[0]), 32'(vt[i].word[15:8] ^ vt[i].word[7:0]));
      got_wr.delete(); got_tx.delete(); exp_wr.delete(); exp_tx.delete();
    end

    // timeout: lo byte one cycle past expiry is a fresh (dropped) hi byte
    send_byte(8'h12, 2'd1);
    idle(TMO);
    send_byte(8'h34, 2'd0);
    settle();
    m_tmo = 1'b1;
    chk("tmo_no_write", 32'(got_wr.size()), 32'd0);
    chk("tmo_flag", 32'(err_tmo), 32'd1);
    got_tx.delete();
    run_word(2'd1, 2'd1, 16'h3456, 3);
    model_word(0, 16'h3456);
    settle();
    cmp_wr(); cmp_tx();
    chk("tmo_sticky", 32'(err_tmo), 32'(m_tmo));
    pulse_clr();
    chk("tmo_clr", 32'(err_tmo), 32'd0);
    // lo byte exactly in the expiry cycle is accepted
    run_word(2'd1, 2'd1, 16'h789A, TMO - 1);
    model_word(0, 16'h789A);
    settle();
    cmp_wr(); cmp_tx();
    chk("tmo_edge_no_err", 32'(err_tmo), 32'd0);

    // DMEM overflow at depth 4
    for (int i = 0; i < 5; i++) begin
      run_word(2'd2, 2'd2, 16'h1000 + 16'(i), 1);
      model_word(1, 16'h1000 + 16'(i));
      settle();
    end
    cmp_wr(); cmp_tx();
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    pulse_clr();
    chk("ovf_clr", 32'(err_ovf), 32'd0);

    // TX held off by tx_busy, then a single launch
    tx_busy = 1'b1;
    run_word(2'd1, 2'd1, 16'hA55A, 1);
    model_word(0, 16'hA55A);
    idle(20);
    settle();
    cmp_wr();
    chk("busy_no_tx", 32'(got_tx.size()), 32'd0);
    uart_sel = 2'd0;
    idle(2); #1;
    chk("stall_tx_pend", 32'(cpu_stall), 32'd1);
    tx_busy = 1'b0;
    settle();
    chk("tx_ff", 32'((got_tx.size() > 0) ? got_tx[0] : 8'h00), 32'hFF);
    cmp_tx();
    chk("stall_released", 32'(cpu_stall), 32'd0);
    // two checksums while busy: only the newer one is sent
    tx_busy = 1'b1;
    run_word(2'd1, 2'd1, 16'h0F3C, 1);
    model_word(0, 16'h0F3C);
    run_word(2'd1, 2'd1, 16'h1234, 1);
    model_word(0, 16'h1234);
    settle();
    cmp_wr();
    tx_busy = 1'b0;
    settle();
    while (exp_tx.size() > 1) void'(exp_tx.pop_front());
    cmp_tx();

    // hi bytes with sel 0 / 3 are dropped
    send_byte(8'hAB, 2'd0);
    send_byte(8'hCD, 2'd3);
    settle();
    chk("sel_drop_wr", 32'(got_wr.size()), 32'd0);
    chk("sel_drop_tx", 32'(got_tx.size()), 32'd0);
    chk("stall_sel3", 32'(cpu_stall), 32'd1);

    // reset during S_WAIT discards the partial word
    send_byte(8'h55, 2'd1);
    idle(3);
    reset = 1'b0;
    #1;
    chk("midreset_outputs", 32'({tx_start, tx_data, imem_we, dmem_we, mem_addr, mem_wdata,
                                 cpu_stall, err_ovf, err_tmo}), 32'd0);
    idle(2);
    reset = 1'b1;
    model_reset();
    send_byte(8'h77, 2'd0);
    settle();
    chk("midreset_no_wr", 32'(got_wr.size()), 32'd0);
    chk("stall_idle", 32'(cpu_stall), 32'd0);
    got_wr.delete(); got_tx.delete();
    run_word(2'd1, 2'd1, 16'hBEEF, 0);
    model_word(0, 16'hBEEF);
    settle();
    cmp_wr(); cmp_tx();

    // randomized words against the model
    for (int i = 0; i < 150; i++) begin
      s = $urandom_range(0, 3);
      w = 16'($urandom);
      if (s == 0 || s == 3) begin
        send_byte(w[15:8], 2'(s));
        settle();
      end else begin
        g = $urandom_range(0, 60);
        if (g >= TMO) begin
          send_byte(w[15:8], 2'(s));
          idle(g);
          m_tmo = 1'b1;
          settle();
        end else begin
          run_word(2'(s), 2'($urandom_range(0, 3)), w, g);
          model_word(s - 1, w);
          settle();
        end
      end
      cmp_wr(); cmp_tx();
      chk("rnd_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("rnd_tmo", 32'(err_tmo), 32'(m_tmo));
      if ($urandom_range(0, 7) == 0) pulse_clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
